// File: rtl/cpumc_arbiter_pkg.sv
// Shared types for the CPU/HCI memory-bus arbiter: ownership states and the
// bus values driven during the idle release cycle.
package cpumc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HCI     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Release cycle is a plain read of address 0 (WRAM), which has no side effects.
  localparam logic REL_R_NW = 1'b1;

endpackage

// File: rtl/cpumc_arbiter.sv
// Hands the CPU memory bus between the RP2A03 and the HCI debug block: stall the
// CPU via RDY, let in-flight writes finish, drain, grant HCI, then one release cycle.
module cpumc_arbiter
  import cpumc_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              hci_req_in,
  output logic              hci_gnt_out,
  input  logic [ADDR_W-1:0] hci_a_in,
  input  logic              hci_r_nw_in,
  input  logic [DATA_W-1:0] hci_d_in,
  output logic [DATA_W-1:0] hci_d_out,
  input  logic [ADDR_W-1:0] cpu_a_in,
  input  logic              cpu_r_nw_in,
  input  logic [DATA_W-1:0] cpu_d_in,
  output logic [DATA_W-1:0] cpu_d_out,
  output logic              cpu_rdy_out,
  output logic [ADDR_W-1:0] bus_a_out,
  output logic              bus_r_nw_out,
  output logic [DATA_W-1:0] bus_d_out,
  input  logic [DATA_W-1:0] bus_d_in,
  output logic [1:0]        owner_out
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_CPU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CPU: begin
        if (hci_req_in) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Write cycles ignore RDY on the 6502, so only stalled reads count as drained.
        if (!hci_req_in) begin
          state_d = ST_CPU;
        end else if (cpu_r_nw_in) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(DRAIN_CYCLES)) state_d = ST_HCI;
        end
      end
      ST_HCI: begin
        if (!hci_req_in) state_d = ST_RELEASE;
      end
      default: state_d = ST_CPU;
    endcase
  end

  assign cpu_rdy_out = (state_q == ST_CPU);
  assign hci_gnt_out = (state_q == ST_HCI);
  assign owner_out   = state_q;
  assign cpu_d_out   = bus_d_in;
  assign hci_d_out   = hci_gnt_out ? bus_d_in : '0;

  always_comb begin
    bus_a_out    = cpu_a_in;
    bus_r_nw_out = cpu_r_nw_in;
    bus_d_out    = cpu_d_in;
    case (state_q)
      ST_HCI: begin
        bus_a_out    = hci_a_in;
        bus_r_nw_out = hci_r_nw_in;
        bus_d_out    = hci_d_in;
      end
      ST_RELEASE: begin
        bus_a_out    = '0;
        bus_r_nw_out = REL_R_NW;
        bus_d_out    = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpumc_arbiter.sv
// Bench for cpumc_arbiter: directed handshake scenarios, then random traffic
// against an ownership model plus a small WRAM behind the bus.
module tb_cpumc_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DRAIN = 2;
  localparam int P_CPU = 0, P_DRAIN = 1, P_HCI = 2, P_REL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          hci_req, hci_gnt, hci_r_nw, cpu_r_nw, cpu_rdy, bus_r_nw;
  logic [AW-1:0] hci_a, cpu_a, bus_a;
  logic [DW-1:0] hci_d, hci_dq, cpu_d, cpu_dq, bus_d, bus_di;
  logic [1:0]    owner;

  logic [DW-1:0] mem [0:2047];

  int n_chk = 0;
  int n_err = 0;

  // reference ownership model
  int m_phase;
  int m_reads;

  always #5 clk = ~clk;

  cpumc_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_in(clk), .rst_in(rst),
    .hci_req_in(hci_req), .hci_gnt_out(hci_gnt),
    .hci_a_in(hci_a), .hci_r_nw_in(hci_r_nw), .hci_d_in(hci_d), .hci_d_out(hci_dq),
    .cpu_a_in(cpu_a), .cpu_r_nw_in(cpu_r_nw), .cpu_d_in(cpu_d), .cpu_d_out(cpu_dq),
    .cpu_rdy_out(cpu_rdy),
    .bus_a_out(bus_a), .bus_r_nw_out(bus_r_nw), .bus_d_out(bus_d), .bus_d_in(bus_di),
    .owner_out(owner)
  );

  assign bus_di = mem[bus_a[10:0]];
  always @(posedge clk) if (!bus_r_nw) mem[bus_a[10:0]] <= bus_d;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = P_CPU; m_reads = 0;
    end else if (m_phase == P_CPU) begin
      if (hci_req) begin m_phase = P_DRAIN; m_reads = 0; end
    end else if (m_phase == P_DRAIN) begin
      if (!hci_req) m_phase = P_CPU;
      else if (cpu_r_nw) begin
        m_reads++;
        if (m_reads >= DRAIN) m_phase = P_HCI;
      end
    end else if (m_phase == P_HCI) begin
      if (!hci_req) m_phase = P_REL;
    end else begin
      m_phase = P_CPU;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all();
    int ea, er, ed, eg;
    eg = (m_phase == P_HCI) ? 1 : 0;
    if (m_phase == P_HCI) begin ea = int'(hci_a); er = int'(hci_r_nw); ed = int'(hci_d); end
    else if (m_phase == P_REL) begin ea = 0; er = 1; ed = 0; end
    else begin ea = int'(cpu_a); er = int'(cpu_r_nw); ed = int'(cpu_d); end
    chk("owner", int'(owner), m_phase);
    chk("rdy", int'(cpu_rdy), (m_phase == P_CPU) ? 1 : 0);
    chk("gnt", int'(hci_gnt), eg);
    chk("bus_a", int'(bus_a), ea);
    chk("bus_r_nw", int'(bus_r_nw), er);
    chk("bus_d", int'(bus_d), ed);
    chk("cpu_d_out", int'(cpu_dq), int'(mem[ea[10:0]]));
    chk("hci_d_out", int'(hci_dq), eg ? int'(mem[ea[10:0]]) : 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
    m_phase = P_CPU; m_reads = 0;
    rst = 1'b1; hci_req = 1'b0; hci_a = '0; hci_r_nw = 1'b1; hci_d = '0;
    cpu_a = 16'h8000; cpu_r_nw = 1'b1; cpu_d = '0;
    tick(); tick();
    rst = 1'b0; #1;

    // reset / idle
    chk("rst_rdy", int'(cpu_rdy), 1);
    chk("rst_gnt", int'(hci_gnt), 0);
    chk("rst_bus_a", int'(bus_a), 16'h8000);
    chk("rst_owner", int'(owner), 0);
    check_all();

    // grant latency with CPU reading
    hci_req = 1'b1;
    tick(); chk("lat_rdy_e0", int'(cpu_rdy), 0); chk("lat_gnt_e0", int'(hci_gnt), 0);
    tick(); chk("lat_gnt_e1", int'(hci_gnt), 0);
    tick(); chk("lat_gnt_e2", int'(hci_gnt), 1);
    hci_a = 16'h0123; hci_r_nw = 1'b0; hci_d = 8'h5A; #1;
    chk("hci_bus_a", int'(bus_a), 16'h0123);
    chk("hci_bus_rnw", int'(bus_r_nw), 0);
    check_all();
    tick();
    hci_r_nw = 1'b1; #1;
    chk("hci_readback", int'(hci_dq), 8'h5A);

    // drop and immediately re-raise: one release cycle, one CPU cycle, then drain
    hci_req = 1'b0;
    tick(); chk("rel_owner", int'(owner), 3); chk("rel_a", int'(bus_a), 0);
    chk("rel_rnw", int'(bus_r_nw), 1); chk("rel_rdy", int'(cpu_rdy), 0);
    hci_req = 1'b1;
    tick(); chk("fair_owner", int'(owner), 0); chk("fair_rdy", int'(cpu_rdy), 1);
    cpu_r_nw = 1'b0; cpu_d = 8'hA5; cpu_a = 16'h0042;
    tick(); chk("redrain_owner", int'(owner), 1);

    // writes during drain hold the count
    for (int i = 0; i < 3; i++) begin
      chk("drw_rnw", int'(bus_r_nw), 0);
      chk("drw_d", int'(bus_d), 8'hA5);
      check_all();
      tick();
      chk("drw_owner", int'(owner), 1);
    end
    cpu_r_nw = 1'b1;
    tick(); chk("drw_gnt_r1", int'(hci_gnt), 0);
    tick(); chk("drw_gnt_r2", int'(hci_gnt), 1);
    chk("drw_mem", int'(mem[11'h042]), 8'hA5);

    // reset while HCI owns the bus
    rst = 1'b1;
    tick();
    rst = 1'b0; hci_req = 1'b0; #1;
    chk("rsth_owner", int'(owner), 0); chk("rsth_gnt", int'(hci_gnt), 0);
    chk("rsth_rdy", int'(cpu_rdy), 1); chk("rsth_bus_a", int'(bus_a), int'(cpu_a));
    check_all();

    // single-cycle request pulse
    hci_req = 1'b1;
    tick(); chk("pulse_rdy0", int'(cpu_rdy), 0); chk("pulse_owner", int'(owner), 1);
    hci_req = 1'b0;
    tick(); chk("pulse_rdy1", int'(cpu_rdy), 1); chk("pulse_gnt", int'(hci_gnt), 0);
    tick(); chk("pulse_owner2", int'(owner), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) hci_req = ~hci_req;
      rst      = ($urandom_range(99) == 0);
      cpu_a    = 16'($urandom);
      cpu_r_nw = ($urandom_range(3) != 0);
      cpu_d    = 8'($urandom);
      hci_a    = 16'($urandom);
      hci_r_nw = 1'($urandom);
      hci_d    = 8'($urandom);
      #1;
      check_all();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
